// File: rtl/ram_stream_reader_if.sv
// Valid/ready word stream with last-word marking.
// The master drives the words and the slave drives ready.
interface ram_stream_reader_if #(
    parameter int WIDTH = 32
) ();
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;
    logic             last;

    modport master (
        output valid,
        output data,
        output last,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  last,
        output ready
    );
endinterface

// File: rtl/ram_stream_reader.sv
// Fetches a run of consecutive words from a registered-read RAM and streams
// them out. A 2-entry skid FIFO covers the one-cycle read latency under backpressure.
module ram_stream_reader #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 64,
    parameter int ADDR_BITS = 6,
    parameter int LEN_BITS  = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic [ADDR_BITS-1:0] i_base_addr,
    input  logic [LEN_BITS-1:0]  i_length,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_ram_read_enable,
    output logic [ADDR_BITS-1:0] o_ram_read_addr,
    input  logic [WIDTH-1:0]     i_ram_dout,
    ram_stream_reader_if.master  m_stream
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [ADDR_BITS-1:0]  r_addr;
    logic [LEN_BITS-1:0]   r_reads_left;
    logic                  r_inflight;
    logic                  r_inflight_last;
    logic                  r_done;

    logic [WIDTH-1:0]      r_fifo_data [2];
    logic                  r_fifo_last [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;

    logic                  w_accept;
    logic                  w_issue;
    logic                  w_issue_last;
    logic                  w_done_next;
    logic                  w_credit;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_valid;
    logic                  w_head_last;
    logic [2:0]            w_occupancy;
    logic [2:0]            w_limit;
    logic [ADDR_BITS-1:0]  w_addr_inc;

    assign w_valid     = (r_count != 2'd0);
    assign w_head_last = r_fifo_last[r_rd_ptr];
    assign w_pop       = w_valid & m_stream.ready;
    assign w_push      = r_inflight;

    // Entries held or about to land, minus the one leaving this cycle, must stay below 2.
    assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight};
    assign w_limit     = 3'd2 + {2'b00, w_pop};
    assign w_credit    = (w_occupancy < w_limit);

    assign w_issue_last = (r_reads_left == LEN_BITS'(1));
    assign w_addr_inc   = (r_addr == ADDR_BITS'(DEPTH - 1)) ? '0 : r_addr + ADDR_BITS'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_issue      = 1'b0;
        w_done_next  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_length != '0) begin
                        w_accept     = 1'b1;
                        w_state_next = ST_RUN;
                    end else begin
                        w_done_next  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (w_credit) begin
                    w_issue = 1'b1;
                    if (w_issue_last) begin
                        w_state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_pop && w_head_last) begin
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr       <= '0;
            r_reads_left <= '0;
        end else if (w_accept) begin
            r_addr       <= i_base_addr;
            r_reads_left <= i_length;
        end else if (w_issue) begin
            r_addr       <= w_addr_inc;
            r_reads_left <= r_reads_left - LEN_BITS'(1);
        end
    end

    // The read issued last cycle has its word on i_ram_dout this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue & w_issue_last;
            r_done          <= w_done_next;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fifo_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_fifo_data[gi] <= '0;
                    r_fifo_last[gi] <= 1'b0;
                end else if (w_push && (r_wr_ptr == 1'(gi))) begin
                    r_fifo_data[gi] <= i_ram_dout;
                    r_fifo_last[gi] <= r_inflight_last;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_busy            = (r_state != ST_IDLE);
    assign o_done            = r_done;
    assign o_ram_read_enable = w_issue;
    assign o_ram_read_addr   = r_addr;

    assign m_stream.valid = w_valid;
    assign m_stream.data  = r_fifo_data[r_rd_ptr];
    assign m_stream.last  = w_valid & w_head_last;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a behavioural registered-read RAM
// preloaded with RAM[i] = i.
`timescale 1ns/1ps
module tb_ram_stream_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [5:0]  base;
    logic [6:0]  len;
    logic        busy;
    logic        done;
    logic        ren;
    logic [5:0]  raddr;
    logic [31:0] rdout;
    logic        m_ready;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem [64];
    logic [31:0] got_q [$];
    logic [5:0]  addr_q [$];
    int          last_idx;
    int          last_cnt;
    int          done_cyc;
    int          max_out;
    int          unstable;

    ram_stream_reader_if #(.WIDTH(32)) s_if ();
    assign s_if.ready = m_ready;

    ram_stream_reader #(
        .WIDTH(32), .DEPTH(64), .ADDR_BITS(6), .LEN_BITS(7)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_start           (start),
        .i_base_addr       (base),
        .i_length          (len),
        .o_busy            (busy),
        .o_done            (done),
        .o_ram_read_enable (ren),
        .o_ram_read_addr   (raddr),
        .i_ram_dout        (rdout),
        .m_stream          (s_if.master)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'(i);
        rdout = '0;
    end

    always @(posedge clk) if (ren) rdout <= mem[raddr];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic issue_start(input logic [5:0] b, input logic [6:0] l);
        @(negedge clk);
        start = 1'b1; base = b; len = l; m_ready = 1'b1;
    endtask

    // Runs cycles 1..budget after issue_start, recording handshakes until done.
    task automatic collect(input bit toggle, input int budget);
        int issued = 0;
        int hs = 0;
        bit prev_stall = 1'b0;
        logic [31:0] prev_data = '0;
        logic prev_last = 1'b0;
        got_q.delete(); addr_q.delete();
        last_idx = -1; last_cnt = 0; done_cyc = -1; max_out = 0; unstable = 0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            start = 1'b0;
            m_ready = toggle ? (c % 2 == 1) : 1'b1;
            #1;
            if (issued - hs > max_out) max_out = issued - hs;
            if (prev_stall && (s_if.valid !== 1'b1 || s_if.data !== prev_data || s_if.last !== prev_last))
                unstable++;
            prev_stall = s_if.valid && !m_ready;
            prev_data  = s_if.data;
            prev_last  = s_if.last;
            if (ren) begin addr_q.push_back(raddr); issued++; end
            if (s_if.valid && m_ready) begin
                got_q.push_back(s_if.data);
                if (s_if.last) begin last_idx = got_q.size() - 1; last_cnt++; end
                hs++;
                $display("xfer c=%0d data=%0d last=%b", c, s_if.data, s_if.last);
            end
            if (done) begin done_cyc = c; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; base = '0; len = '0; m_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (ren !== 1'b0) begin n_bad++; $display("FAIL reset_ren: got %b want 0", ren); end
        n_cmp++; if (raddr !== 6'd0) begin n_bad++; $display("FAIL reset_addr: got %0d want 0", raddr); end
        n_cmp++; if (s_if.valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", s_if.valid); end
        n_cmp++; if (s_if.last !== 1'b0) begin n_bad++; $display("FAIL reset_last: got %b want 0", s_if.last); end
        n_cmp++; if (s_if.data !== 32'd0) begin n_bad++; $display("FAIL reset_data: got %0d want 0", s_if.data); end
        $display("reset checked");
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // base=4 len=8, ready held high: cycle-exact timing of every output.
    task automatic test_basic();
        issue_start(6'd4, 7'd8);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            n_cmp++;
            if (s_if.valid !== (c >= 3 && c <= 10)) begin
                n_bad++; $display("FAIL basic_valid c=%0d: got %b want %b", c, s_if.valid, (c >= 3 && c <= 10));
            end
            if (c >= 3 && c <= 10) begin
                n_cmp++;
                if (s_if.data !== 32'(c + 1)) begin n_bad++; $display("FAIL basic_data c=%0d: got %0d want %0d", c, s_if.data, c + 1); end
                $display("basic c=%0d data=%0d last=%b", c, s_if.data, s_if.last);
            end
            n_cmp++; if (s_if.last !== (c == 10)) begin n_bad++; $display("FAIL basic_last c=%0d: got %b want %b", c, s_if.last, (c == 10)); end
            n_cmp++; if (done !== (c == 11)) begin n_bad++; $display("FAIL basic_done c=%0d: got %b want %b", c, done, (c == 11)); end
            n_cmp++; if (busy !== (c <= 10)) begin n_bad++; $display("FAIL basic_busy c=%0d: got %b want %b", c, busy, (c <= 10)); end
            n_cmp++; if (ren !== (c <= 8)) begin n_bad++; $display("FAIL basic_ren c=%0d: got %b want %b", c, ren, (c <= 8)); end
            if (c <= 8) begin
                n_cmp++; if (raddr !== 6'(3 + c)) begin n_bad++; $display("FAIL basic_addr c=%0d: got %0d want %0d", c, raddr, 3 + c); end
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_w [8] = '{32'd60, 32'd61, 32'd62, 32'd63, 32'd0, 32'd1, 32'd2, 32'd3};
        issue_start(6'd60, 7'd8);
        collect(1'b0, 30);
        n_cmp++; if (got_q.size() != 8) begin n_bad++; $display("FAIL wrap_count: got %0d want 8", got_q.size()); end
        n_cmp++; if (addr_q.size() != 8) begin n_bad++; $display("FAIL wrap_reads: got %0d want 8", addr_q.size()); end
        if (got_q.size() == 8 && addr_q.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                n_cmp++; if (got_q[i] !== exp_w[i]) begin n_bad++; $display("FAIL wrap_data[%0d]: got %0d want %0d", i, got_q[i], exp_w[i]); end
                n_cmp++; if (32'(addr_q[i]) !== exp_w[i]) begin n_bad++; $display("FAIL wrap_addr[%0d]: got %0d want %0d", i, addr_q[i], exp_w[i]); end
            end
        end
        n_cmp++; if (last_idx != 7 || last_cnt != 1) begin n_bad++; $display("FAIL wrap_last: got idx %0d cnt %0d want idx 7 cnt 1", last_idx, last_cnt); end
        n_cmp++; if (done_cyc != 11) begin n_bad++; $display("FAIL wrap_done_cycle: got %0d want 11", done_cyc); end
    endtask

    task automatic test_backpressure();
        issue_start(6'd16, 7'd5);
        collect(1'b1, 60);
        n_cmp++; if (done_cyc < 0) begin n_bad++; $display("FAIL bp_done: got none within budget want a done pulse"); end
        n_cmp++; if (got_q.size() != 5) begin n_bad++; $display("FAIL bp_count: got %0d want 5", got_q.size()); end
        if (got_q.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++; if (got_q[i] !== 32'(16 + i)) begin n_bad++; $display("FAIL bp_data[%0d]: got %0d want %0d", i, got_q[i], 16 + i); end
            end
        end
        n_cmp++; if (last_idx != 4 || last_cnt != 1) begin n_bad++; $display("FAIL bp_last: got idx %0d cnt %0d want idx 4 cnt 1", last_idx, last_cnt); end
        n_cmp++; if (unstable != 0) begin n_bad++; $display("FAIL bp_stable: got %0d changes while stalled want 0", unstable); end
        n_cmp++; if (max_out > 2) begin n_bad++; $display("FAIL bp_occupancy: got %0d want <= 2", max_out); end
        n_cmp++; if (addr_q.size() != 5) begin n_bad++; $display("FAIL bp_reads: got %0d want 5", addr_q.size()); end
    endtask

    task automatic test_len0();
        issue_start(6'd5, 7'd0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            n_cmp++; if (done !== (c == 1)) begin n_bad++; $display("FAIL len0_done c=%0d: got %b want %b", c, done, (c == 1)); end
            n_cmp++; if (ren !== 1'b0) begin n_bad++; $display("FAIL len0_ren c=%0d: got %b want 0", c, ren); end
            n_cmp++; if (s_if.valid !== 1'b0) begin n_bad++; $display("FAIL len0_valid c=%0d: got %b want 0", c, s_if.valid); end
            n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL len0_busy c=%0d: got %b want 0", c, busy); end
        end
        $display("len0 done pulse checked");
    endtask

    // Start during busy is ignored; start in the done cycle is accepted.
    task automatic test_back_to_back();
        logic [31:0] seen [$];
        int done_cnt = 0;
        issue_start(6'd4, 7'd8);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            start = (c == 3) || (c == 11);
            base  = (c == 3) ? 6'd20 : 6'd30;
            len   = (c == 3) ? 7'd2 : 7'd3;
            #1;
            if (s_if.valid && m_ready) begin
                seen.push_back(s_if.data);
                $display("b2b c=%0d data=%0d last=%b", c, s_if.data, s_if.last);
            end
            if (done) done_cnt++;
            if (c == 4) begin
                n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy: got %b want 1", busy); end
            end
            if (c == 11) begin
                n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL b2b_done_c11: got %b want 1", done); end
            end
        end
        n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL b2b_done_count: got %0d want 1", done_cnt); end
        n_cmp++; if (seen.size() != 8) begin n_bad++; $display("FAIL b2b_count: got %0d want 8", seen.size()); end
        if (seen.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                n_cmp++; if (seen[i] !== 32'(4 + i)) begin n_bad++; $display("FAIL b2b_data[%0d]: got %0d want %0d", i, seen[i], 4 + i); end
            end
        end
        collect(1'b0, 20);
        n_cmp++; if (got_q.size() != 3) begin n_bad++; $display("FAIL b2b_second_count: got %0d want 3", got_q.size()); end
        if (got_q.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++; if (got_q[i] !== 32'(30 + i)) begin n_bad++; $display("FAIL b2b_second_data[%0d]: got %0d want %0d", i, got_q[i], 30 + i); end
            end
        end
        n_cmp++; if (done_cyc != 6) begin n_bad++; $display("FAIL b2b_second_done: got %0d want 6", done_cyc); end
    endtask

    task automatic test_reset_mid();
        int sent = 0;
        int spurious = 0;
        issue_start(6'd0, 7'd8);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (s_if.valid && m_ready) begin
                sent++;
                $display("rstmid c=%0d data=%0d", c, s_if.data);
            end
        end
        n_cmp++; if (sent != 3) begin n_bad++; $display("FAIL rstmid_sent: got %0d want 3", sent); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        n_cmp++; if (ren !== 1'b0) begin n_bad++; $display("FAIL rstmid_ren: got %b want 0", ren); end
        n_cmp++; if (raddr !== 6'd0) begin n_bad++; $display("FAIL rstmid_addr: got %0d want 0", raddr); end
        n_cmp++; if (s_if.valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid: got %b want 0", s_if.valid); end
        n_cmp++; if (s_if.data !== 32'd0) begin n_bad++; $display("FAIL rstmid_data: got %0d want 0", s_if.data); end
        n_cmp++; if (s_if.last !== 1'b0) begin n_bad++; $display("FAIL rstmid_last: got %b want 0", s_if.last); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rstmid_done: got %b want 0", done); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            if (done !== 1'b0 || s_if.valid !== 1'b0) spurious++;
        end
        n_cmp++; if (spurious != 0) begin n_bad++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", spurious); end
        issue_start(6'd10, 7'd4);
        collect(1'b0, 20);
        n_cmp++; if (got_q.size() != 4) begin n_bad++; $display("FAIL rstmid_fresh_count: got %0d want 4", got_q.size()); end
        if (got_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++; if (got_q[i] !== 32'(10 + i)) begin n_bad++; $display("FAIL rstmid_fresh_data[%0d]: got %0d want %0d", i, got_q[i], 10 + i); end
            end
        end
        n_cmp++; if (done_cyc != 7) begin n_bad++; $display("FAIL rstmid_fresh_done: got %0d want 7", done_cyc); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_len0();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
